// File: rtl/uart_boot_loader.sv
// rtl/uart_boot_loader.sv - length-prefixed UART image loader into a stallable word memory
module uart_boot_loader #(
  parameter int                WORD_BYTES = 4,
  parameter int                ADDR_W     = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR  = '0,
  parameter logic [ADDR_W-1:0] ADDR_STEP  = 1,
  parameter int unsigned       MAX_WORDS  = 65536,
  parameter int                FIFO_DEPTH = 8,
  parameter bit                BIG_ENDIAN = 1'b0,
  parameter logic [7:0]        ACK_BYTE   = 8'hAA,
  parameter logic [7:0]        NAK_BYTE   = 8'h55
) (
  input  logic                    clock_i,
  input  logic                    reset_i,
  input  logic                    rx_ready_i,
  input  logic [7:0]              rx_data_i,
  input  logic                    rx_ferr_i,
  input  logic                    tx_busy_i,
  output logic                    tx_start_o,
  output logic [7:0]              tx_data_o,
  output logic                    mem_en_o,
  output logic                    mem_we_o,
  output logic [ADDR_W-1:0]       mem_addr_o,
  output logic [8*WORD_BYTES-1:0] mem_wd_o,
  input  logic                    mem_stall_i,
  output logic                    program_loaded_o,
  output logic [31:0]             words_written_o,
  output logic                    err_overrun_o,
  output logic                    err_frame_o
);
  localparam int DW = 8 * WORD_BYTES;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int BW = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;

  typedef enum logic [2:0] {S_HDR, S_DATA, S_WRITE, S_ACK, S_NAK, S_DONE} state_t;

  state_t            state_q;
  logic [7:0]        fifo_mem [FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [PW:0]       cnt_q;
  logic [1:0]        hdr_cnt_q;
  logic [31:0]       len_q, len_d;
  logic [BW-1:0]     byte_cnt_q;
  logic [DW-1:0]     word_q, word_d;
  logic [ADDR_W-1:0] addr_q, mem_addr_q;
  logic [DW-1:0]     mem_wd_q;
  logic              mem_en_q, tx_start_q, loaded_q, ovr_q, ferr_q;
  logic [7:0]        tx_data_q, head;
  logic [31:0]       words_q, words_d;
  logic              fifo_full, fifo_empty, intake, push, pop, accept;

  always_comb begin
    fifo_full  = (cnt_q == (PW+1)'(FIFO_DEPTH));
    fifo_empty = (cnt_q == '0);
    // A pending memory request blocks popping so the word buffer cannot be overwritten
    pop        = (state_q == S_HDR || state_q == S_DATA) && !fifo_empty && !mem_en_q;
    intake     = rx_ready_i && (state_q != S_DONE);
    push       = intake && !rx_ferr_i && (!fifo_full || pop);
    head       = fifo_mem[rd_ptr_q];
    len_d      = {head, len_q[31:8]};
    word_d     = BIG_ENDIAN ? ((word_q << 8) | DW'(head))
                            : ((word_q >> 8) | (DW'(head) << (DW - 8)));
    accept     = mem_en_q && !mem_stall_i;
    words_d    = words_q + 32'd1;
  end

  always_ff @(posedge clock_i) begin
    if (push) fifo_mem[wr_ptr_q] <= rx_data_i;
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= S_HDR;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      hdr_cnt_q  <= '0;
      len_q      <= '0;
      byte_cnt_q <= '0;
      word_q     <= '0;
      addr_q     <= BASE_ADDR;
      mem_addr_q <= '0;
      mem_wd_q   <= '0;
      mem_en_q   <= 1'b0;
      tx_start_q <= 1'b0;
      tx_data_q  <= '0;
      loaded_q   <= 1'b0;
      words_q    <= '0;
      ovr_q      <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      tx_start_q <= 1'b0;
      if (intake && rx_ferr_i) ferr_q <= 1'b1;
      if (intake && !rx_ferr_i && !push) ovr_q <= 1'b1;
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      if (push && !pop)      cnt_q <= cnt_q + (PW+1)'(1);
      else if (!push && pop) cnt_q <= cnt_q - (PW+1)'(1);

      case (state_q)
        S_HDR: if (pop) begin
          len_q     <= len_d;
          hdr_cnt_q <= hdr_cnt_q + 2'd1;
          if (hdr_cnt_q == 2'd3) begin
            if ({1'b0, len_d} > 33'(MAX_WORDS)) state_q <= S_NAK;
            else if (len_d == '0)               state_q <= S_ACK;
            else                                state_q <= S_DATA;
          end
        end
        S_DATA: if (pop) begin
          word_q <= word_d;
          if (byte_cnt_q == BW'(WORD_BYTES - 1)) begin
            byte_cnt_q <= '0;
            mem_wd_q   <= word_d;
            mem_addr_q <= addr_q;
            mem_en_q   <= 1'b1;
            state_q    <= S_WRITE;
          end else begin
            byte_cnt_q <= byte_cnt_q + BW'(1);
          end
        end
        S_WRITE: if (accept) begin
          mem_en_q <= 1'b0;
          words_q  <= words_d;
          addr_q   <= addr_q + ADDR_STEP;
          state_q  <= (words_d == len_q) ? S_ACK : S_DATA;
        end
        S_ACK: if (!tx_busy_i) begin
          tx_start_q <= 1'b1;
          tx_data_q  <= ACK_BYTE;
          state_q    <= S_DONE;
        end
        S_NAK: if (!tx_busy_i) begin
          tx_start_q <= 1'b1;
          tx_data_q  <= NAK_BYTE;
          state_q    <= S_HDR;
          // Rejected header: anything already queued belongs to the bad attempt
          wr_ptr_q   <= '0;
          rd_ptr_q   <= '0;
          cnt_q      <= '0;
        end
        S_DONE: loaded_q <= 1'b1;
        default: state_q <= S_HDR;
      endcase
    end
  end

  assign tx_start_o       = tx_start_q;
  assign tx_data_o        = tx_data_q;
  assign mem_en_o         = mem_en_q;
  assign mem_we_o         = mem_en_q;
  assign mem_addr_o       = mem_addr_q;
  assign mem_wd_o         = mem_wd_q;
  assign program_loaded_o = loaded_q;
  assign words_written_o  = words_q;
  assign err_overrun_o    = ovr_q;
  assign err_frame_o      = ferr_q;
endmodule

// File: doc/uart_boot_loader.md
Name: uart_boot_loader

Overview:
Parametrised successor to the single-purpose program loader that streams UART bytes straight into instruction BRAM. Receives a length-prefixed image over the UART byte interface, buffers bytes in a small FIFO, and assembles WORD_BYTES-byte words. Writes each word to a stallable memory port at an auto-incrementing address. Replies with an ACK/NAK byte on the UART transmitter, then holds program_loaded to release the core from reset.

Parameters:
WORD_BYTES, 4, bytes per memory word (1..8); data width = 8*WORD_BYTES
ADDR_W, 32, memory address width
BASE_ADDR, 0, address of first word written
ADDR_STEP, 1, address increment per word (1 = word addressing, WORD_BYTES = byte addressing)
MAX_WORDS, 65536, largest accepted image length in words
FIFO_DEPTH, 8, byte FIFO depth (power of two, >=2)
BIG_ENDIAN, 0, 0: first byte of a word -> bits [7:0]; 1: first byte -> MSB
ACK_BYTE, 8'hAA, byte sent on successful load
NAK_BYTE, 8'h55, byte sent on rejected header

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high reset
rx_ready  in  1  one-cycle pulse, rx_data valid
rx_data  in  8  received byte
rx_ferr  in  1  framing error, qualified by rx_ready
tx_busy  in  1  transmitter busy
tx_start  out  1  one-cycle pulse launching tx_data
tx_data  out  8  byte to transmit
mem_en  out  1  memory request
mem_we  out  1  write enable (equals mem_en)
mem_addr  out  ADDR_W  write address
mem_wd  out  8*WORD_BYTES  write data
mem_stall  in  1  memory not accepting; request held while high
program_loaded  out  1  image complete; sticky until reset
words_written  out  32  count of words accepted by memory
err_overrun  out  1  sticky: byte dropped because FIFO full
err_frame  out  1  sticky: byte dropped due to rx_ferr

Behaviour:
- Reset (async, any state): all outputs 0, FIFO empty, FSM = HDR, address = BASE_ADDR, byte counters 0. Reset mid-load discards the partial image.
- Byte intake, every state: rx_ready & rx_ferr -> byte dropped, err_frame set. rx_ready & FIFO full -> byte dropped, err_overrun set. Otherwise push. Push and pop in the same cycle are legal at full or empty (push on full+pop is accepted).
- Pop: one byte per cycle, only in HDR/DATA while FIFO non-empty and no memory request pending.
- HDR: collect 4 bytes little-endian into len (32 bit), independent of BIG_ENDIAN. After the 4th byte:
  - len > MAX_WORDS -> NAK
  - len == 0 -> ACK
  - else -> DATA
- DATA: shift popped bytes into the word per BIG_ENDIAN. The byte completing a word loads mem_wd/mem_addr and asserts mem_en=mem_we=1 in the next cycle (WRITE).
- WRITE: request held with stable addr/data while mem_stall=1. On a cycle with mem_en & !mem_stall the word is accepted:
  - words_written++, address += ADDR_STEP (wraps modulo 2^ADDR_W)
  - mem_en drops next cycle
  - go to ACK if words_written reaches len, else DATA
  Bytes still enter the FIFO during WRITE.
- ACK/NAK: wait for tx_busy=0, then pulse tx_start one cycle with tx_data = ACK_BYTE/NAK_BYTE. tx_data is held until the next transmission.
  - ACK -> DONE
  - NAK -> HDR with FIFO flushed in the same cycle
- DONE: program_loaded=1 (registered, asserted the cycle after tx_start). Further rx bytes are ignored and the FIFO is not written. Memory is idle.
- Latency, no stall, FIFO empty: last byte of word on rx_ready cycle T -> pushed T, popped T+1, mem_en high T+2.
- tx_start is never asserted while tx_busy=1. At most one tx_start per load attempt.

Test Plan:
- Header 02 00 00 00, bytes 11 22 33 44 55 66 77 88, no stall -> writes addr0=0x44332211, addr1=0x88776655; one tx_start with tx_data=0xAA; program_loaded=1; words_written=2.
- Same image with BIG_ENDIAN=1, ADDR_STEP=4, BASE_ADDR=0x100 -> addr 0x100=0x11223344, addr 0x104=0x55667788.
- mem_stall high 5 cycles on first write while 8 further bytes arrive back-to-back -> mem_addr/mem_wd stable throughout, FIFO absorbs bytes, err_overrun=0, both words correct. Repeat with FIFO_DEPTH=2 and 4 queued bytes -> err_overrun=1.
- Header len=MAX_WORDS+1 -> tx_data=0x55 pulse, no mem_en; then a valid header of len 0 -> 0xAA, program_loaded=1.
- rx_ferr on the 2nd data byte -> byte dropped, err_frame=1, remaining bytes shift the alignment (verify the resulting word value). tx_busy held high 10 cycles at ACK time -> tx_start delayed until tx_busy=0.
- Assert reset during the 2nd word -> all outputs 0 immediately; a fresh full image afterwards loads from BASE_ADDR correctly.
